// File: rtl/maze_mem_pkg.sv
// maze_mem_pkg: cell encoding, FSM states and cell width shared by the maze store
package maze_mem_pkg;
    localparam int CELL_W = 2;
    localparam logic [CELL_W-1:0] FREE = 2'd0;
    localparam logic [CELL_W-1:0] WALL = 2'd1;
    localparam logic [CELL_W-1:0] PATH = 2'd2;
    typedef enum logic [1:0] {S_LOAD, S_SERVE, S_DUMP_RD, S_DUMP_OUT} state_e;
endpackage

// File: rtl/maze_cell_ram.sv
// maze_cell_ram: simple dual-port cell RAM, port A writes, port B registered read (old data on collision), no reset
module maze_cell_ram
    import maze_mem_pkg::*;
#(
    parameter int AW = 12
) (
    input  logic              clk,
    input  logic              we_a,
    input  logic [AW-1:0]     addr_a,
    input  logic [CELL_W-1:0] wd_a,
    input  logic              re_b,
    input  logic [AW-1:0]     addr_b,
    output logic [CELL_W-1:0] rd_b
);
    logic [CELL_W-1:0] mem [2**AW];

    // Write and read share the edge so a colliding read returns the pre-write cell
    always_ff @(posedge clk) begin
        if (we_a) mem[addr_a] <= wd_a;
        if (re_b) rd_b <= mem[addr_b];
    end
endmodule

// File: rtl/maze_mem.sv
// maze_mem: maze cell store answering solver reads/marks, with load and dump streams; MAZE_MEM_PATH_COUNT_EN adds path_count
module maze_mem
    import maze_mem_pkg::*;
#(
    parameter int maze_width = 6
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  load_valid,
    input  logic [CELL_W-1:0]     load_data,
    output logic                  load_ready,
    output logic                  maze_ready,
    input  logic [maze_width-1:0] row,
    input  logic [maze_width-1:0] col,
    input  logic                  maze_oe,
    input  logic                  maze_we,
    output logic                  maze_in,
    input  logic                  dump_start,
    output logic                  dump_valid,
    output logic [CELL_W-1:0]     dump_data,
    input  logic                  dump_ready,
    output logic                  dump_done
`ifdef MAZE_MEM_PATH_COUNT_EN
    ,
    output logic [2*maze_width:0] path_count
`endif
);
    localparam int AW = 2 * maze_width;
    localparam logic [AW-1:0] LAST = '1;

    state_e            state_q, state_d;
    logic [AW-1:0]     load_addr_q, load_addr_d;
    logic [AW-1:0]     dump_addr_q, dump_addr_d;
    logic              oe_pend_q, oe_pend_d;
    logic              maze_in_q, maze_in_d;
    logic              dump_done_q, dump_done_d;
    logic              load_fire, dump_fire;
    logic              we_a, re_b;
    logic [AW-1:0]     addr_a, addr_b;
    logic [CELL_W-1:0] wd_a, rd_b;

    maze_cell_ram #(.AW(AW)) u_ram (
        .clk    (clk),
        .we_a   (we_a),
        .addr_a (addr_a),
        .wd_a   (wd_a),
        .re_b   (re_b),
        .addr_b (addr_b),
        .rd_b   (rd_b)
    );

    // State register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) state_q <= S_LOAD;
        else     state_q <= state_d;
    end

    // Next-state: load pass, serve solver, then alternating read/present per dump cell
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            S_LOAD:     state_d = (load_valid && load_addr_q == LAST) ? S_SERVE : S_LOAD;
            S_SERVE:    state_d = dump_start ? S_DUMP_RD : S_SERVE;
            S_DUMP_RD:  state_d = S_DUMP_OUT;
            S_DUMP_OUT: state_d = !dump_ready ? S_DUMP_OUT : (dump_addr_q == LAST ? S_SERVE : S_DUMP_RD);
        endcase
    end

    // Outputs and RAM port steering; solver reads also fire on marks so the old cell is visible
    always_comb begin
        load_ready = state_q == S_LOAD;
        maze_ready = state_q == S_SERVE;
        dump_valid = state_q == S_DUMP_OUT;
        load_fire  = load_ready && load_valid;
        dump_fire  = dump_valid && dump_ready;
        dump_data  = dump_valid ? rd_b : '0;
        dump_done  = dump_done_q;
        we_a       = load_fire || (maze_ready && maze_we);
        addr_a     = load_ready ? load_addr_q : {row, col};
        wd_a       = load_ready ? load_data : PATH;
        re_b       = (maze_ready && (maze_oe || maze_we)) || state_q == S_DUMP_RD;
        addr_b     = (state_q == S_DUMP_RD) ? dump_addr_q : {row, col};
        maze_in    = maze_in_d;
    end

    // Counter and flag next values; maze_in shows fresh RAM data the cycle after a read, then holds it
    always_comb begin
        load_addr_d = load_addr_q + AW'(load_fire);
        dump_addr_d = dump_fire ? dump_addr_q + AW'(1) : ((maze_ready && dump_start) ? '0 : dump_addr_q);
        dump_done_d = dump_fire && dump_addr_q == LAST;
        oe_pend_d   = maze_ready && maze_oe;
        maze_in_d   = oe_pend_q ? (rd_b == WALL) : maze_in_q;
    end

    // Datapath registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            load_addr_q <= '0;
            dump_addr_q <= '0;
            oe_pend_q   <= 1'b0;
            maze_in_q   <= 1'b0;
            dump_done_q <= 1'b0;
        end else begin
            load_addr_q <= load_addr_d;
            dump_addr_q <= dump_addr_d;
            oe_pend_q   <= oe_pend_d;
            maze_in_q   <= maze_in_d;
            dump_done_q <= dump_done_d;
        end
    end

`ifdef MAZE_MEM_PATH_COUNT_EN
    logic          we_pend_q, we_pend_d;
    logic [AW:0]   path_count_q, path_count_d;

    // Count a mark one cycle later, once the pre-write cell value is back from the RAM
    always_comb begin
        we_pend_d    = maze_ready && maze_we;
        path_count_d = load_ready ? '0 : path_count_q + (AW+1)'(we_pend_q && rd_b != PATH);
    end

    // Path counter registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            we_pend_q    <= 1'b0;
            path_count_q <= '0;
        end else begin
            we_pend_q    <= we_pend_d;
            path_count_q <= path_count_d;
        end
    end

    assign path_count = path_count_q;
`endif
endmodule

// File: tb/tb_maze_mem.sv
// tb_maze_mem: randomized self-checking bench for maze_mem at maze_width=2
module tb_maze_mem;
    localparam int W = 2;
    localparam int N = 1 << (2 * W);

    logic         clk = 1'b0;
    logic         rst;
    logic         load_valid;
    logic [1:0]   load_data;
    logic         load_ready;
    logic         maze_ready;
    logic [W-1:0] row, col;
    logic         maze_oe, maze_we;
    logic         maze_in;
    logic         dump_start;
    logic         dump_valid;
    logic [1:0]   dump_data;
    logic         dump_ready;
    logic         dump_done;
`ifdef MAZE_MEM_PATH_COUNT_EN
    logic [2*W:0] path_count;
`endif

    int tests = 0;
    int fails = 0;
    int ref_mem [N];
    int ref_cnt;
    logic exp_in;

    maze_mem #(.maze_width(W)) dut (
        .clk        (clk),
        .rst        (rst),
        .load_valid (load_valid),
        .load_data  (load_data),
        .load_ready (load_ready),
        .maze_ready (maze_ready),
        .row        (row),
        .col        (col),
        .maze_oe    (maze_oe),
        .maze_we    (maze_we),
        .maze_in    (maze_in),
        .dump_start (dump_start),
        .dump_valid (dump_valid),
        .dump_data  (dump_data),
        .dump_ready (dump_ready),
        .dump_done  (dump_done)
`ifdef MAZE_MEM_PATH_COUNT_EN
        ,
        .path_count (path_count)
`endif
    );

    always #5 clk = ~clk;

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic idle;
        load_valid = 0; load_data = 0; maze_oe = 0; maze_we = 0;
        dump_start = 0; dump_ready = 0; row = 0; col = 0;
    endtask

    task automatic do_reset;
        idle;
        rst = 1;
        tick;
        tick;
        rst = 0;
        ref_cnt = 0;
        exp_in = 0;
        tick;
    endtask

    // Streams ref_mem into the DUT; noisy mode adds idle gaps and junk solver/dump inputs that must be ignored
    task automatic load_maze(input bit noisy);
        for (int i = 0; i < N; i++) begin
            if (noisy && $urandom_range(0, 1) == 1) begin
                load_valid = 0;
                maze_oe = 1'($urandom); maze_we = 1'($urandom); dump_start = 1'($urandom);
                row = W'($urandom); col = W'($urandom);
                tick;
            end
            tests++;
            if (load_ready !== 1'b1 || maze_ready !== 1'b0) begin
                fails++;
                $display("FAIL load_hs cell %0d: load_ready=%b maze_ready=%b, want 1/0", i, load_ready, maze_ready);
            end
            load_valid = 1;
            load_data = 2'(ref_mem[i]);
            if (noisy) begin
                maze_oe = 1'($urandom); maze_we = 1'($urandom); dump_start = 1'($urandom);
                row = W'($urandom); col = W'($urandom);
            end
            tick;
        end
        idle;
        tests++;
        if (maze_ready !== 1'b1 || load_ready !== 1'b0 || maze_in !== 1'b0) begin
            fails++;
            $display("FAIL load_done: maze_ready=%b load_ready=%b maze_in=%b, want 1/0/0", maze_ready, load_ready, maze_in);
        end
    endtask

    // One solver cycle; expected maze_in and array contents come from the cell rules
    task automatic access(input int r, input int c, input bit oe, input bit we);
        int a;
        a = r * (1 << W) + c;
        row = W'(r); col = W'(c); maze_oe = oe; maze_we = we;
        if (oe) exp_in = (ref_mem[a] == 1);
        if (we) begin
            if (ref_mem[a] != 2) ref_cnt++;
            ref_mem[a] = 2;
        end
        tick;
        maze_oe = 0; maze_we = 0;
        tests++;
        if (maze_in !== exp_in) begin
            fails++;
            $display("FAIL access (%0d,%0d) oe=%b we=%b: maze_in=%b, want %b", r, c, oe, we, maze_in, exp_in);
        end
    endtask

    // Dump the whole array; mode 1 toggles dump_ready 1010..., mode 0 randomizes it
    task automatic do_dump(input bit mode);
        int idx = 0;
        int dones = 0;
        dump_start = 1;
        tick;
        dump_start = 0;
        for (int cyc = 0; cyc < 120; cyc++) begin
            dump_ready = mode ? (cyc % 2 == 0) : 1'($urandom);
            if (dump_done === 1'b1) dones++;
            if (dump_valid === 1'b1) begin
                tests++;
                if (idx >= N || dump_data !== 2'(ref_mem[idx])) begin
                    fails++;
                    $display("FAIL dump_cell %0d: data=%0d, want %0d", idx, dump_data, idx < N ? ref_mem[idx] : -1);
                end
                if (dump_ready) idx++;
            end else if (dump_data !== 2'd0) begin
                tests++;
                fails++;
                $display("FAIL dump_idle_data: data=%0d, want 0", dump_data);
            end
            tick;
        end
        dump_ready = 0;
        tests++;
        if (idx != N || dones != 1 || maze_ready !== 1'b1 || dump_valid !== 1'b0) begin
            fails++;
            $display("FAIL dump_end: cells=%0d dones=%0d maze_ready=%b dump_valid=%b, want %0d/1/1/0",
                     idx, dones, maze_ready, dump_valid, N);
        end
    endtask

    task automatic test_reset;
        idle;
        rst = 1;
        #3;
        tests++;
        if (load_ready !== 1'b1 || maze_ready !== 1'b0 || maze_in !== 1'b0 || dump_valid !== 1'b0 ||
            dump_data !== 2'd0 || dump_done !== 1'b0) begin
            fails++;
            $display("FAIL reset_outputs: lr=%b mr=%b mi=%b dv=%b dd=%0d dn=%b, want 1/0/0/0/0/0",
                     load_ready, maze_ready, maze_in, dump_valid, dump_data, dump_done);
        end
`ifdef MAZE_MEM_PATH_COUNT_EN
        tests++;
        if (path_count !== '0) begin
            fails++;
            $display("FAIL reset_path_count: %0d, want 0", path_count);
        end
`endif
        do_reset;
    endtask

    task automatic test_load_read;
        for (int i = 0; i < N; i++) ref_mem[i] = 0;
        ref_mem[5] = 1;
        do_reset;
        load_maze(0);
        access(1, 1, 1, 0);
        access(0, 0, 1, 0);
        access(1, 1, 1, 0);
        access(3, 3, 0, 0);
        access(0, 2, 0, 0);
    endtask

    task automatic test_write_read;
        access(2, 3, 0, 1);
        access(2, 3, 1, 0);
        do_dump(1);
    endtask

    task automatic test_simul;
        access(1, 1, 1, 1);
        access(1, 1, 1, 0);
        do_dump(1);
    endtask

    task automatic test_async_reset;
        access(1, 1, 1, 0);
        ref_mem[5] = 1;
        for (int i = 0; i < N; i++) ref_mem[i] = $urandom_range(0, 3);
        ref_mem[5] = 1;
        do_reset;
        load_maze(0);
        access(1, 1, 1, 0);
        #2;
        rst = 1;
        #1;
        tests++;
        if (load_ready !== 1'b1 || maze_ready !== 1'b0 || maze_in !== 1'b0) begin
            fails++;
            $display("FAIL async_rst_serve: lr=%b mr=%b mi=%b, want 1/0/0", load_ready, maze_ready, maze_in);
        end
        #1;
        rst = 0;
        exp_in = 0;
        ref_cnt = 0;
        tick;
        for (int i = 0; i < 7; i++) begin
            load_valid = 1;
            load_data = 2'($urandom);
            tick;
        end
        #2;
        rst = 1;
        #1;
        load_valid = 0;
        tests++;
        if (load_ready !== 1'b1 || maze_ready !== 1'b0) begin
            fails++;
            $display("FAIL async_rst_load: lr=%b mr=%b, want 1/0", load_ready, maze_ready);
        end
        #1;
        rst = 0;
        tick;
        for (int i = 0; i < N; i++) ref_mem[i] = $urandom_range(0, 3);
        load_maze(0);
        do_dump(0);
    endtask

    task automatic test_random;
        for (int i = 0; i < N; i++) ref_mem[i] = $urandom_range(0, 3);
        do_reset;
        load_maze(1);
        for (int k = 0; k < 60; k++)
            access($urandom_range(0, (1 << W) - 1), $urandom_range(0, (1 << W) - 1), 1'($urandom), 1'($urandom));
        tick;
        tick;
`ifdef MAZE_MEM_PATH_COUNT_EN
        tests++;
        if (path_count !== (2*W+1)'(ref_cnt)) begin
            fails++;
            $display("FAIL random_path_count: %0d, want %0d", path_count, ref_cnt);
        end
`endif
        do_dump(0);
    endtask

`ifdef MAZE_MEM_PATH_COUNT_EN
    task automatic test_path_count;
        for (int i = 0; i < N; i++) ref_mem[i] = 0;
        do_reset;
        load_maze(0);
        access(0, 1, 0, 1);
        access(0, 1, 0, 1);
        access(0, 2, 0, 1);
        tick;
        tick;
        tests++;
        if (path_count !== (2*W+1)'(2)) begin
            fails++;
            $display("FAIL path_count_repeat: %0d, want 2", path_count);
        end
    endtask
`endif

    initial begin
        test_reset;
        test_load_read;
        test_write_read;
        test_simul;
        test_async_reset;
        test_random;
`ifdef MAZE_MEM_PATH_COUNT_EN
        test_path_count;
`endif
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
